// File: rtl/switch_pkg.sv
/*--------------------------------------------------------------------
 | Module  : switch_pkg
 | Desc    : Shared types and defaults for the switch arbiter slice.
 | Rev     : 1.0  initial release
 --------------------------------------------------------------------*/
`default_nettype none

package switch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int c_n_port = 4;
  localparam int c_aw_dev = 2;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
/*--------------------------------------------------------------------
 | Module  : rr_pick
 | Desc    : Combinational round-robin selector starting at i_ptr.
 | Rev     : 1.0  initial release
 --------------------------------------------------------------------*/
`default_nettype none

module rr_pick
  import switch_pkg::*;
#(
  parameter int N_PORT = c_n_port,
  parameter int SW     = 2
) (
  input  logic [N_PORT-1:0] i_elig,
  input  logic [SW-1:0]     i_ptr,
  output logic [SW-1:0]     o_idx,
  output logic              o_any_valid
);

  int w_cand;

  always_comb begin
    o_idx       = '0;
    o_any_valid = 1'b0;
    w_cand      = 0;
    for (int i = 0; i < N_PORT; i++) begin
      w_cand = (int'(i_ptr) + i) % N_PORT;
      if (!o_any_valid && i_elig[w_cand]) begin
        o_idx       = SW'(w_cand);
        o_any_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/switch_arbiter.sv
/*--------------------------------------------------------------------
 | Module  : switch_arbiter
 | Desc    : Round-robin crossbar arbiter with handshake hold and watchdog.
 | Rev     : 1.0  initial release
 --------------------------------------------------------------------*/
`default_nettype none

module switch_arbiter
  import switch_pkg::*;
#(
  parameter int N_PORT  = c_n_port,
  parameter int AW_DEV  = c_aw_dev,
  parameter int SW      = 2,
  parameter int TIMEOUT = 15,
  parameter int TW      = 4,
  localparam int N_DEV  = 1 << AW_DEV
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_PORT-1:0]        rqt_i,
  input  logic [N_PORT-1:0]        validtx_i,
  input  logic [N_PORT*AW_DEV-1:0] adr_i,
  input  logic [N_DEV-1:0]         full_i,
  output logic [N_PORT-1:0]        gnt_o,
  output logic [SW-1:0]            sel_o,
  output logic [N_DEV-1:0]         wen_o,
  output logic                     busy_o,
  output logic                     err_o
);

  state_t              r_state;
  logic [SW-1:0]       r_ptr;
  logic [SW-1:0]       r_sel;
  logic [TW-1:0]       r_cnt;
  logic [N_PORT-1:0]   r_gnt;
  logic [N_DEV-1:0]    r_wen;
  logic                r_err;

  logic [N_PORT-1:0]   w_elig;
  logic [SW-1:0]       w_pick;
  logic                w_any;
  logic [AW_DEV-1:0]   w_pick_adr;
  logic [SW-1:0]       w_ptr_next;

  // A port whose destination FIFO is full simply drops out of this round.
  for (genvar k = 0; k < N_PORT; k++) begin : g_elig
    assign w_elig[k] = rqt_i[k] & ~full_i[adr_i[k*AW_DEV +: AW_DEV]];
  end

  rr_pick #(
    .N_PORT (N_PORT),
    .SW     (SW)
  ) u_rr_pick (
    .i_elig      (w_elig),
    .i_ptr       (r_ptr),
    .o_idx       (w_pick),
    .o_any_valid (w_any)
  );

  always_comb begin
    w_pick_adr = '0;
    for (int k = 0; k < N_PORT; k++) begin
      if (w_pick == SW'(k)) w_pick_adr = adr_i[k*AW_DEV +: AW_DEV];
    end
  end

  assign w_ptr_next = (r_sel == SW'(N_PORT - 1)) ? '0 : r_sel + SW'(1);

  // The counter runs from the GRANT edge, so HOLD lasts at most TIMEOUT cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_wen   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_wen <= '0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel   <= w_pick;
            r_gnt   <= N_PORT'(1) << w_pick;
            r_wen   <= N_DEV'(1) << w_pick_adr;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          r_ptr   <= w_ptr_next;
          r_cnt   <= r_cnt + TW'(1);
          r_state <= HOLD;
        end
        HOLD: begin
          if (!validtx_i[r_sel]) begin
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_state <= RELEASE;
          end else if (r_cnt == TW'(TIMEOUT)) begin
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b1;
            r_state <= RELEASE;
          end else begin
            r_cnt <= r_cnt + TW'(1);
          end
        end
        RELEASE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt_o  = r_gnt;
  assign sel_o  = r_sel;
  assign wen_o  = r_wen;
  assign err_o  = r_err;
  assign busy_o = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_switch_arbiter.sv
/*--------------------------------------------------------------------
 | Module  : tb_switch_arbiter
 | Desc    : Directed vector bench for switch_arbiter.
 | Rev     : 1.0  initial release
 --------------------------------------------------------------------*/
`default_nettype none

module tb_switch_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] rqt;
  logic [3:0] vtx;
  logic [7:0] adr;
  logic [3:0] full;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [3:0] wen;
  logic       busy;
  logic       err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] rqt;
    logic [3:0] vtx;
    logic [7:0] adr;
    logic [3:0] full;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [3:0] wen;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  switch_arbiter dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .rqt_i     (rqt),
    .validtx_i (vtx),
    .adr_i     (adr),
    .full_i    (full),
    .gnt_o     (gnt),
    .sel_o     (sel),
    .wen_o     (wen),
    .busy_o    (busy),
    .err_o     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] v, input logic [7:0] a,
                     input logic [3:0] f, input logic [3:0] g, input logic [1:0] s,
                     input logic [3:0] w, input logic b);
    tbl.push_back('{rqt: r, vtx: v, adr: a, full: f, gnt: g, sel: s, wen: w, busy: b});
  endtask

  task automatic set_in(input logic [3:0] r, input logic [3:0] v, input logic [7:0] a,
                        input logic [3:0] f);
    rqt = r; vtx = v; adr = a; full = f;
  endtask

  initial begin
    logic [3:0] g;
    int         p;

    set_in(4'h0, 4'h0, 8'h00, 4'h0);
    rst_n = 1'b0;
    repeat (2) step();
    check("reset gnt", gnt, 0);
    check("reset sel", sel, 0);
    check("reset wen", wen, 0);
    check("reset busy", busy, 0);
    check("reset err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention: all four request, port k addresses FIFO k, validtx drops in HOLD.
    for (int t = 0; t < 5; t++) begin
      p = t % 4;
      g = 4'b0001 << p;
      add(4'hF, 4'hF,      8'hE4, 4'h0, g,    2'(p), g,    1'b1);
      add(4'hF, 4'hF,      8'hE4, 4'h0, g,    2'(p), 4'h0, 1'b1);
      add(4'hF, 4'hF & ~g, 8'hE4, 4'h0, 4'h0, 2'(p), 4'h0, 1'b1);
      add(4'hF, 4'hF,      8'hE4, 4'h0, 4'h0, 2'(p), 4'h0, 1'b0);
    end
    // Single request from port 2 to FIFO 1 (ptr is 1 here).
    add(4'b0100, 4'b0100, 8'h10, 4'h0, 4'b0100, 2'd2, 4'b0010, 1'b1);
    add(4'b0100, 4'b0100, 8'h10, 4'h0, 4'b0100, 2'd2, 4'b0000, 1'b1);
    add(4'b0100, 4'b0100, 8'h10, 4'h0, 4'b0100, 2'd2, 4'b0000, 1'b1);
    add(4'b0000, 4'b0000, 8'h10, 4'h0, 4'b0000, 2'd2, 4'b0000, 1'b1);
    add(4'b0000, 4'b0000, 8'h10, 4'h0, 4'b0000, 2'd2, 4'b0000, 1'b0);
    // Full masking: port 0 targets full FIFO 3, so port 1 wins; then port 0 (ptr=2).
    add(4'b0011, 4'b0011, 8'h07, 4'b1000, 4'b0010, 2'd1, 4'b0010, 1'b1);
    add(4'b0011, 4'b0011, 8'h07, 4'b1000, 4'b0010, 2'd1, 4'b0000, 1'b1);
    add(4'b0011, 4'b0001, 8'h07, 4'b1000, 4'b0000, 2'd1, 4'b0000, 1'b1);
    add(4'b0011, 4'b0011, 8'h07, 4'b0000, 4'b0000, 2'd1, 4'b0000, 1'b0);
    add(4'b0011, 4'b0011, 8'h07, 4'b0000, 4'b0001, 2'd0, 4'b1000, 1'b1);
    add(4'b0011, 4'b0011, 8'h07, 4'b0000, 4'b0001, 2'd0, 4'b0000, 1'b1);
    add(4'b0000, 4'b0000, 8'h07, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b1);
    add(4'b0000, 4'b0000, 8'h07, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0);

    foreach (tbl[i]) begin
      set_in(tbl[i].rqt, tbl[i].vtx, tbl[i].adr, tbl[i].full);
      step();
      check($sformatf("v%0d gnt", i), gnt, tbl[i].gnt);
      check($sformatf("v%0d sel", i), sel, tbl[i].sel);
      check($sformatf("v%0d wen", i), wen, tbl[i].wen);
      check($sformatf("v%0d busy", i), busy, tbl[i].busy);
      check($sformatf("v%0d err", i), err, 0);
    end

    // Timeout on port 1 (ptr=1): 15 HOLD cycles, then forced release with err.
    set_in(4'b0010, 4'b0010, 8'h04, 4'h0);
    step();
    check("to grant", gnt, 4'b0010);
    for (int i = 0; i < 15; i++) begin
      step();
      check($sformatf("to hold%0d gnt", i), gnt, 4'b0010);
      check($sformatf("to hold%0d err", i), err, 0);
    end
    step();
    check("to err", err, 1);
    check("to gnt", gnt, 0);
    check("to busy", busy, 1);
    set_in(4'h0, 4'h0, 8'h00, 4'h0);
    step();
    check("to err pulse", err, 0);
    check("to idle busy", busy, 0);
    // ptr must now be 2: ports 1 and 2 request, port 2 wins.
    set_in(4'b0110, 4'b0110, 8'h00, 4'h0);
    step();
    check("to ptr gnt", gnt, 4'b0100);
    step();
    set_in(4'h0, 4'h0, 8'h00, 4'h0);
    repeat (2) step();

    // Asynchronous reset while wen is high (ptr=3 before reset).
    set_in(4'b0001, 4'b0001, 8'h02, 4'h0);
    step();
    check("ar wen pre", wen, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    check("ar gnt", gnt, 0);
    check("ar wen", wen, 0);
    check("ar busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(4'b1001, 4'b1001, 8'h00, 4'h0);
    step();
    check("ar ptr0 gnt", gnt, 4'b0001);
    check("ar ptr0 sel", sel, 0);
    step();
    set_in(4'h0, 4'h0, 8'h00, 4'h0);
    repeat (2) step();

    // Address change during HOLD on port 1 (ptr=1).
    set_in(4'b0010, 4'b0010, 8'h04, 4'h0);
    step();
    check("ac wen", wen, 4'b0010);
    step();
    adr = 8'h08;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("ac hold%0d wen", i), wen, 0);
      check($sformatf("ac hold%0d sel", i), sel, 1);
      check($sformatf("ac hold%0d gnt", i), gnt, 4'b0010);
    end
    set_in(4'h0, 4'h0, 8'h08, 4'h0);
    step();
    check("ac rel wen", wen, 0);
    check("ac rel gnt", gnt, 0);
    step();
    check("ac idle wen", wen, 0);
    check("ac idle sel", sel, 1);
    check("ac idle busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
